// File: rtl/i2c_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_sequencer_pkg
//  Description : Shared types and defaults for the I2C command sequencer and
//                its command FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_cmd_sequencer_pkg;

    typedef logic [7:0] address_t;
    typedef logic [7:0] byte_t;

    // One buffered transaction; rw=1 is a read, wdata is don't-care for reads.
    typedef struct packed {
        logic     rw;
        address_t addr;
        byte_t    wdata;
    } seq_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } seq_state_t;

    localparam int SEQ_FIFO_DEPTH  = 4;
    localparam int SEQ_TIMEOUT_CYC = 1024;
    localparam int SEQ_LAUNCH_CYC  = 1;
    localparam int SEQ_CMD_W       = $bits(seq_cmd_t);

    // Larger of two counts; sizes the shared launch/timeout counter.
    function automatic int seq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_fifo
//  Description : Synchronous command FIFO. Pointers carry one extra MSB so
//                that full and empty are distinguished without a counter.
//                Pushes while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_fifo
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = SEQ_FIFO_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 push_i,
    input  logic [SEQ_CMD_W-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [SEQ_CMD_W-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SEQ_CMD_W-1:0] mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;
    logic                 push_en;
    logic                 pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array: written on accepted push; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Pointer update; reset discards every buffered entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_sequencer
//  Description : Command front-end for the I2C top level. Buffers read/write
//                commands, launches them on the master enable/address/data
//                lines, waits for a rising done (with timeout) and returns
//                read data and status over a valid/ready response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_sequencer
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = SEQ_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC,
    parameter int LAUNCH_CYC  = SEQ_LAUNCH_CYC
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_rw_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       rsp_rw_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic       master_en_o,
    output logic       r_w_en_o,
    output logic [7:0] mem_addr_o,
    output logic [7:0] data_o,
    input  logic       i2c_done_i,
    input  logic [7:0] i2c_rdata_i,
    output logic       busy_o
);

    // One counter serves both the launch pulse width and the timeout.
    localparam int         CNT_MAX     = seq_max(TIMEOUT_CYC, LAUNCH_CYC);
    localparam int         CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LAUNCH_LAST  = CNT_W'(LAUNCH_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    seq_cmd_t              launch_q, launch_d;
    logic                  pend_q, pend_d;
    byte_t                 pend_data_q, pend_data_d;
    logic                  rsp_rw_q, rsp_rw_d;
    byte_t                 rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_valid_q;
    logic                  master_en_q;
    logic                  done_q;
    logic                  done_rise;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [SEQ_CMD_W-1:0]  fifo_head;
    seq_cmd_t              head_cmd;
    seq_cmd_t              new_cmd;

    assign new_cmd.rw    = cmd_rw_i;
    assign new_cmd.addr  = cmd_addr_i;
    assign new_cmd.wdata = cmd_wdata_i;
    assign head_cmd      = fifo_head;

    assign cmd_ready_o = ~fifo_full;
    assign fifo_push   = cmd_valid_i & ~fifo_full;

    i2c_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fifo_push),
        .push_data_i (new_cmd),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A done level already high at launch never counts; only a fresh rise.
    assign done_rise = i2c_done_i & ~done_q;

    // Sequencer next-state: pop, launch pulse, done/timeout wait, response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        launch_d    = launch_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        rsp_rw_d    = rsp_rw_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    launch_d = head_cmd;
                    pend_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                // A rise during the enable pulse is remembered for WAIT_DONE.
                if (done_rise) begin
                    pend_d      = 1'b1;
                    pend_data_d = i2c_rdata_i;
                end
                if (cnt_q == LAUNCH_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                // Completion is checked before timeout so a coincident rise wins.
                if (done_rise || pend_q) begin
                    rsp_rw_d    = launch_q.rw;
                    rsp_err_d   = 1'b0;
                    if (!launch_q.rw) begin
                        rsp_rdata_d = '0;
                    end else if (pend_q) begin
                        rsp_rdata_d = pend_data_q;
                    end else begin
                        rsp_rdata_d = i2c_rdata_i;
                    end
                    pend_d  = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rsp_rw_d    = launch_q.rw;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, launch and response registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            launch_q    <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            rsp_rw_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            master_en_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            launch_q    <= launch_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            rsp_rw_q    <= rsp_rw_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= (state_d == RESP);
            master_en_q <= (state_d == LAUNCH);
            done_q      <= i2c_done_i;
        end
    end

    assign master_en_o = master_en_q;
    assign r_w_en_o    = launch_q.rw;
    assign mem_addr_o  = launch_q.addr;
    assign data_o      = launch_q.wdata;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rw_o    = rsp_rw_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != IDLE) | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_cmd_sequencer
//  Description : Directed self-checking bench. Instance A uses the default
//                timeout; instance B (timeout 16) shares the stimulus and is
//                observed only in the timeout section.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;
    import i2c_cmd_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_rw, rsp_ready, i2c_done;
    logic [7:0] cmd_addr, cmd_wdata, i2c_rdata;

    logic       a_cmd_ready, a_rsp_valid, a_rsp_rw, a_rsp_err, a_master_en, a_r_w_en, a_busy;
    logic [7:0] a_rsp_rdata, a_mem_addr, a_data;
    logic       b_cmd_ready, b_rsp_valid, b_rsp_rw, b_rsp_err, b_master_en, b_r_w_en, b_busy;
    logic [7:0] b_rsp_rdata, b_mem_addr, b_data;

    logic       sel_b = 1'b0;
    logic       m_cmd_ready, m_rsp_valid, m_rsp_rw, m_rsp_err, m_master_en, m_r_w_en, m_busy;
    logic [7:0] m_rsp_rdata, m_mem_addr, m_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2c_cmd_sequencer dut_a (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(a_cmd_ready),
        .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rw_o(a_rsp_rw),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err), .master_en_o(a_master_en),
        .r_w_en_o(a_r_w_en), .mem_addr_o(a_mem_addr), .data_o(a_data),
        .i2c_done_i(i2c_done), .i2c_rdata_i(i2c_rdata), .busy_o(a_busy)
    );

    i2c_cmd_sequencer #(.TIMEOUT_CYC(16)) dut_b (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(b_cmd_ready),
        .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rw_o(b_rsp_rw),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err), .master_en_o(b_master_en),
        .r_w_en_o(b_r_w_en), .mem_addr_o(b_mem_addr), .data_o(b_data),
        .i2c_done_i(i2c_done), .i2c_rdata_i(i2c_rdata), .busy_o(b_busy)
    );

    assign m_cmd_ready = sel_b ? b_cmd_ready : a_cmd_ready;
    assign m_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_rw    = sel_b ? b_rsp_rw    : a_rsp_rw;
    assign m_rsp_err   = sel_b ? b_rsp_err   : a_rsp_err;
    assign m_rsp_rdata = sel_b ? b_rsp_rdata : a_rsp_rdata;
    assign m_master_en = sel_b ? b_master_en : a_master_en;
    assign m_r_w_en    = sel_b ? b_r_w_en    : a_r_w_en;
    assign m_mem_addr  = sel_b ? b_mem_addr  : a_mem_addr;
    assign m_data      = sel_b ? b_data      : a_data;
    assign m_busy      = sel_b ? b_busy      : a_busy;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic rw, input logic [7:0] addr, input logic [7:0] wd, output bit acc);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wd;
        acc       = m_cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (!m_master_en && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, " launch"}, 32'(m_master_en), 1);
    endtask

    // Waits for launch, checks launch lines and pulse width, then raises
    // done 'delay' cycles after the master_en cycle and drops it again.
    task automatic serve(input string tag, input logic rw, input logic [7:0] addr,
                         input logic [7:0] wd, input int delay, input logic [7:0] rd);
        wait_en(tag);
        check_eq({tag, " r_w_en"}, 32'(m_r_w_en), 32'(rw));
        check_eq({tag, " mem_addr"}, 32'(m_mem_addr), 32'(addr));
        check_eq({tag, " data"}, 32'(m_data), 32'(wd));
        tick();
        check_eq({tag, " en pulse"}, 32'(m_master_en), 0);
        repeat (delay - 1) tick();
        i2c_rdata = rd;
        i2c_done  = 1'b1;
        tick();
        i2c_done  = 1'b0;
    endtask

    // Waits for a response, checks it, consumes it with rsp_ready=1.
    task automatic get_rsp(input string tag, input logic rw, input logic [7:0] rd, input logic err);
        int n = 0;
        while (!m_rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, " rsp_valid"}, 32'(m_rsp_valid), 1);
        check_eq({tag, " rsp_rw"}, 32'(m_rsp_rw), 32'(rw));
        check_eq({tag, " rsp_rdata"}, 32'(m_rsp_rdata), 32'(rd));
        check_eq({tag, " rsp_err"}, 32'(m_rsp_err), 32'(err));
        rsp_ready = 1'b1;
        tick();
        check_eq({tag, " rsp drop"}, 32'(m_rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1);
    end

    initial begin
        bit acc;
        int nacc;
        int seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        rsp_ready = 1'b1; i2c_done = 1'b0; i2c_rdata = 8'h00;
        #12;
        check_eq("rst cmd_ready", 32'(m_cmd_ready), 1);
        check_eq("rst rsp_valid", 32'(m_rsp_valid), 0);
        check_eq("rst master_en", 32'(m_master_en), 0);
        check_eq("rst busy", 32'(m_busy), 0);
        check_eq("rst mem_addr", 32'(m_mem_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Write: done rises 20 cycles after master_en.
        push(1'b0, 8'h12, 8'hA5, acc);
        check_eq("wr accept", 32'(acc), 1);
        serve("wr", 1'b0, 8'h12, 8'hA5, 20, 8'h5A);
        get_rsp("wr", 1'b0, 8'h00, 1'b0);

        // Read: master_en first high in the cycle after accept edge + 1.
        push(1'b1, 8'h12, 8'h00, acc);
        check_eq("rd en after accept", 32'(m_master_en), 0);
        check_eq("rd busy", 32'(m_busy), 1);
        tick();
        check_eq("rd en after pop", 32'(m_master_en), 1);
        serve("rd", 1'b1, 8'h12, 8'h00, 3, 8'hA5);
        get_rsp("rd", 1'b1, 8'hA5, 1'b0);

        // Stale done level across launch must not complete.
        i2c_done = 1'b1;
        repeat (2) tick();
        push(1'b0, 8'h33, 8'h44, acc);
        wait_en("stale");
        repeat (10) tick();
        check_eq("stale no rsp", 32'(m_rsp_valid), 0);
        i2c_done = 1'b0;
        repeat (5) tick();
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        get_rsp("stale", 1'b0, 8'h00, 1'b0);

        // Backpressure: one transaction stalled in RESP, then offer 6 more.
        rsp_ready = 1'b0;
        push(1'b1, 8'h40, 8'h00, acc);
        serve("bpA", 1'b1, 8'h40, 8'h00, 2, 8'h11);
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            push(1'(i), 8'h50 + 8'(i), 8'h60 + 8'(i), acc);
            if (acc) nacc++;
        end
        check_eq("bp accepted", 32'(nacc), 4);
        check_eq("bp cmd_ready low", 32'(m_cmd_ready), 0);
        check_eq("bp still stalled", 32'(m_rsp_valid), 1);
        check_eq("bp no relaunch", 32'(m_master_en), 0);
        get_rsp("bpA", 1'b1, 8'h11, 1'b0);
        check_eq("bp ready before pop", 32'(m_cmd_ready), 0);
        tick();
        check_eq("bp ready after pop", 32'(m_cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("bp%0d", i), 1'(i), 8'h50 + 8'(i), 8'h60 + 8'(i), 2, 8'h70 + 8'(i));
            get_rsp($sformatf("bp%0d", i), 1'(i), (i % 2 == 1) ? 8'h70 + 8'(i) : 8'h00, 1'b0);
        end

        // Reset while waiting for done with two commands queued.
        push(1'b0, 8'h80, 8'h01, acc);
        push(1'b0, 8'h81, 8'h02, acc);
        push(1'b0, 8'h82, 8'h03, acc);
        check_eq("mid busy", 32'(m_busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid master_en", 32'(m_master_en), 0);
        check_eq("mid rsp_valid", 32'(m_rsp_valid), 0);
        check_eq("mid busy after rst", 32'(m_busy), 0);
        check_eq("mid cmd_ready", 32'(m_cmd_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            i2c_done = (i == 8);
            tick();
            if (m_master_en || m_rsp_valid) seen++;
        end
        i2c_done = 1'b0;
        check_eq("mid quiet", 32'(seen), 0);
        push(1'b0, 8'h90, 8'h91, acc);
        serve("post", 1'b0, 8'h90, 8'h91, 4, 8'h00);
        get_rsp("post", 1'b0, 8'h00, 1'b0);

        // Timeout section on the 16-cycle instance.
        sel_b = 1'b1;
        do_reset();
        i2c_rdata = 8'hFF;
        push(1'b1, 8'h21, 8'h00, acc);
        wait_en("to");
        repeat (16) tick();
        check_eq("to not yet", 32'(m_rsp_valid), 0);
        tick();
        check_eq("to on time", 32'(m_rsp_valid), 1);
        get_rsp("to", 1'b1, 8'h00, 1'b1);
        push(1'b1, 8'h22, 8'h00, acc);
        serve("to next", 1'b1, 8'h22, 8'h00, 3, 8'h3C);
        get_rsp("to next", 1'b1, 8'h3C, 1'b0);

        // Done rise in the very cycle the timeout would fire.
        push(1'b0, 8'h23, 8'h24, acc);
        wait_en("tie");
        repeat (16) tick();
        check_eq("tie not yet", 32'(m_rsp_valid), 0);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        get_rsp("tie", 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Upstream command front-end for the I2C top level. Accepts read/write transactions over a valid/ready interface and buffers them in a small command FIFO. Launches each transaction on the I2C master's enable/address/data inputs, waits for the slave-side done, and returns read data and status over a valid/ready response interface. Its data output feeds the top-level Data input, which enters the shift register in parallel-load mode; shift-register mode control is outside this block.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2
TIMEOUT_CYC, 1024, cycles allowed in WAIT_DONE before the transaction is aborted
LAUNCH_CYC, 1, width of the master_en pulse in cycles, minimum 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_rw  in  1  1 = read, 0 = write
cmd_addr  in  address_t  target memory address
cmd_wdata  in  byte_t  write data; ignored for reads
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rw  out  1  rw of the completed command
rsp_rdata  out  byte_t  read data; 0 for writes and on error
rsp_err  out  1  transaction timed out
master_en  out  1  to I2C Master_en
r_w_en  out  1  to I2C R_W_en
mem_addr  out  address_t  to I2C Mem_Addr
data  out  byte_t  to I2C Data path
i2c_done  in  1  done from the I2C controller
i2c_rdata  in  byte_t  data_out from the I2C controller
busy  out  1  state != IDLE, or FIFO not empty

Behaviour:
- Reset (asynchronous, immediate): state IDLE, FIFO empty, done_q=0, timeout counter=0, and all outputs 0 except cmd_ready=1.
- Push: on the edge where cmd_valid&cmd_ready, {rw,addr,wdata} is written to the FIFO. cmd_ready = !full; there is no bypass when full.
- Pop: in IDLE with the FIFO non-empty, the head entry is popped and loaded into the launch registers, and the state moves to LAUNCH on the same edge. An accept on edge N into an empty FIFO pops on edge N+1; master_en is high in the cycle after N+1.
- Simultaneous push and pop is legal at any occupancy below full, and occupancy is unchanged.
- LAUNCH:
  - master_en=1 for LAUNCH_CYC cycles, then the state moves to WAIT_DONE.
  - Counter clears on entry.
- Launch-register hold: r_w_en, mem_addr and data are driven from the launch registers. They are held stable from LAUNCH through the RESP handshake. They keep their last value in IDLE.
- Done detection: done_q <= i2c_done every cycle, and done_rise = i2c_done & ~done_q. A level that is already high at launch does not complete a transaction. Only a rise observed during LAUNCH or WAIT_DONE is accepted.
- WAIT_DONE:
  - On done_rise: rsp_rdata = rw ? i2c_rdata : 0, rsp_err=0, rsp_rw=rw, and the state moves to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYC-1 without done_rise: rsp_err=1, rsp_rdata=0, and the state moves to RESP.
  - If done_rise and timeout occur in the same cycle, done_rise wins.
- RESP:
  - rsp_valid=1, and the response fields are stable until the rsp_valid&rsp_ready edge. On that edge rsp_valid drops and the state returns to IDLE.
  - The next pop happens no earlier than the following edge.
  - Backpressure on rsp_ready stalls launches only. The FIFO still accepts commands until full.
- master_en is registered and never asserted outside LAUNCH.
- A reset during any state aborts the transaction without a response. Buffered commands are discarded.

Decomposition:
- my_pkg additions:
  - seq_cmd_t packed struct {rw, address_t addr, byte_t wdata}
  - seq_state_t enum {IDLE, LAUNCH, WAIT_DONE, RESP}
  - default constants SEQ_FIFO_DEPTH, SEQ_TIMEOUT_CYC
  - address_t and byte_t reused from the package
- Sub-module i2c_cmd_fifo:
  - synchronous FIFO of seq_cmd_t with async active-high reset
  - push, pop, full, empty
  - wrapping pointers with an extra MSB for the full/empty distinction
- Sequencer FSM, done edge detector and timeout counter live in i2c_cmd_sequencer.

Test Plan:
- Write: cmd {rw=0, addr=0x12, wdata=0xA5}; i2c_done rises 20 cycles after master_en -> master_en one cycle high with r_w_en=0, mem_addr=0x12, data=0xA5; rsp_valid with rsp_rw=0, rsp_rdata=0x00, rsp_err=0.
- Read: cmd {rw=1, addr=0x12}; i2c_rdata=0xA5 when i2c_done rises -> rsp_rdata=0xA5, rsp_err=0, and master_en first high in the cycle after accept edge +1.
- Full/backpressure: hold rsp_ready=0 and push 6 commands -> exactly 4 accepted (cmd_ready low afterward), 1 launched. Release rsp_ready -> 4 responses returned in issue order, and cmd_ready reasserts after the first pop.
- Timeout: TIMEOUT_CYC=16 with i2c_done held at 0 -> rsp_err=1, rsp_rdata=0 arrives 16 cycles after entering WAIT_DONE. The next command then launches normally.
- Stale done: i2c_done held high across launch -> no completion. Drop it and re-raise it 5 cycles later -> completes on that rise. Also check done_rise coincident with the timeout cycle -> rsp_err=0.
- Reset mid-op: assert reset in WAIT_DONE with 2 commands queued -> master_en, rsp_valid and busy are 0 immediately, and cmd_ready=1. After release, no response or launch occurs until a new command is pushed.
